// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - writeback request/regfile bus for regfile_write_arbiter
//
// Signals:
//   AluWrite/AluReg/AluData -> AluReady      ALU writeback request and acceptance
//   MemValid/MemReg/MemData -> MemReady      memory/load writeback request and acceptance
//   RegWrite/WriteRegister/WriteData         registered register-file write port
//   QueryReg1/2 -> Pending1/2                decode hazard query (only with WB_PENDING_QUERY_EN)
// Modports: slave = arbiter side, master = requester/regfile side.
interface regfile_write_arbiter_if;
    logic        AluWrite;
    logic [4:0]  AluReg;
    logic [31:0] AluData;
    logic        AluReady;
    logic        MemValid;
    logic [4:0]  MemReg;
    logic [31:0] MemData;
    logic        MemReady;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
`ifdef WB_PENDING_QUERY_EN
    logic [4:0]  QueryReg1;
    logic [4:0]  QueryReg2;
    logic        Pending1;
    logic        Pending2;

    modport slave (
        input  AluWrite, AluReg, AluData, MemValid, MemReg, MemData, QueryReg1, QueryReg2,
        output AluReady, MemReady, RegWrite, WriteRegister, WriteData, Pending1, Pending2
    );
    modport master (
        output AluWrite, AluReg, AluData, MemValid, MemReg, MemData, QueryReg1, QueryReg2,
        input  AluReady, MemReady, RegWrite, WriteRegister, WriteData, Pending1, Pending2
    );
`else
    modport slave (
        input  AluWrite, AluReg, AluData, MemValid, MemReg, MemData,
        output AluReady, MemReady, RegWrite, WriteRegister, WriteData
    );
    modport master (
        output AluWrite, AluReg, AluData, MemValid, MemReg, MemData,
        input  AluReady, MemReady, RegWrite, WriteRegister, WriteData
    );
`endif
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - merges ALU and memory writebacks onto the single regfile write port
//
// Ports:
//   Clk    clock, posedge
//   Reset  asynchronous active-high, clears all state
//   bus    regfile_write_arbiter_if.slave (ALU request, memory request, regfile write port)
// Parameters: DEPTH (memory FIFO entries, power of two >= 2), STARVE_LIMIT (>= 1).
// Optional feature macro: WB_PENDING_QUERY_EN adds the Pending1/Pending2 hazard query.
module regfile_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input logic                    Clk,
    input logic                    Reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       ent_reg_q  [DEPTH];
    logic [31:0]      ent_data_q [DEPTH];
    logic [DEPTH-1:0] ent_vld_q, ent_vld_d;
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             reg_write_q, reg_write_d;
    logic [4:0]       wr_reg_q, wr_reg_d;
    logic [31:0]      wr_data_q, wr_data_d;

    logic full, empty, head_vld, alu_ready, mem_ready;
    logic alu_issue, push, pop;

    always_comb begin
        full      = (count_q == CW'(DEPTH));
        empty     = (count_q == '0);
        // Slots are invalidated on pop, so an unoccupied slot never reads as valid.
        head_vld  = !empty && ent_vld_q[rd_ptr_q];
        alu_ready = !((starve_q == SW'(STARVE_LIMIT)) && head_vld);
        mem_ready = !full && !Reset;
        // Register-0 writes complete the handshake but go nowhere.
        alu_issue = bus.AluWrite && alu_ready && (bus.AluReg != 5'd0);
        push      = bus.MemValid && mem_ready && (bus.MemReg != 5'd0);
        pop       = !alu_issue && !empty;

        count_d = count_q + CW'(push) - CW'(pop);

        ent_vld_d = ent_vld_q;
        if (alu_issue) begin
            // The ALU write is younger than everything already queued for the same register.
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_vld_q[i] && (ent_reg_q[i] == bus.AluReg)) ent_vld_d[i] = 1'b0;
            end
        end
        if (pop)  ent_vld_d[rd_ptr_q] = 1'b0;
        // Set after the kill: a same-cycle memory write to the same register is younger.
        if (push) ent_vld_d[wr_ptr_q] = 1'b1;

        starve_d = starve_q;
        if (alu_issue && head_vld) begin
            if (starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + SW'(1);
        end else if (pop) begin
            starve_d = '0;
        end

        reg_write_d = 1'b0;
        wr_reg_d    = wr_reg_q;
        wr_data_d   = wr_data_q;
        if (alu_issue) begin
            reg_write_d = 1'b1;
            wr_reg_d    = bus.AluReg;
            wr_data_d   = bus.AluData;
        end else if (pop && ent_vld_q[rd_ptr_q]) begin
            reg_write_d = 1'b1;
            wr_reg_d    = ent_reg_q[rd_ptr_q];
            wr_data_d   = ent_data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg_q[i]  <= '0;
                ent_data_q[i] <= '0;
            end
            ent_vld_q   <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            reg_write_q <= 1'b0;
            wr_reg_q    <= '0;
            wr_data_q   <= '0;
        end else begin
            if (push) begin
                ent_reg_q[wr_ptr_q]  <= bus.MemReg;
                ent_data_q[wr_ptr_q] <= bus.MemData;
                wr_ptr_q             <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            ent_vld_q   <= ent_vld_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            reg_write_q <= reg_write_d;
            wr_reg_q    <= wr_reg_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign bus.AluReady      = alu_ready;
    assign bus.MemReady      = mem_ready;
    assign bus.RegWrite      = reg_write_q;
    assign bus.WriteRegister = wr_reg_q;
    assign bus.WriteData     = wr_data_q;

`ifdef WB_PENDING_QUERY_EN
    logic pend1, pend2;

    always_comb begin
        pend1 = reg_write_q && (wr_reg_q == bus.QueryReg1);
        pend2 = reg_write_q && (wr_reg_q == bus.QueryReg2);
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld_q[i] && (ent_reg_q[i] == bus.QueryReg1)) pend1 = 1'b1;
            if (ent_vld_q[i] && (ent_reg_q[i] == bus.QueryReg2)) pend2 = 1'b1;
        end
    end

    assign bus.Pending1 = pend1 && (bus.QueryReg1 != 5'd0);
    assign bus.Pending2 = pend2 && (bus.QueryReg2 != 5'd0);
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    regfile_write_arbiter_if bus();

    regfile_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        aw;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mr;
        logic [31:0] md;
        logic        e_ar;
        logic        e_mr;
        logic        e_we;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
    } vec_t;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    vec_t vecs[$];
    wr_t  sb[$];
    wr_t  last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic v(input logic aw, input logic [4:0] ar, input logic [31:0] ad,
                     input logic mv, input logic [4:0] mr, input logic [31:0] md,
                     input logic e_ar, input logic e_mr,
                     input logic e_we, input logic [4:0] e_reg, input logic [31:0] e_data);
        vec_t t;
        t.aw = aw; t.ar = ar; t.ad = ad; t.mv = mv; t.mr = mr; t.md = md;
        t.e_ar = e_ar; t.e_mr = e_mr; t.e_we = e_we; t.e_reg = e_reg; t.e_data = e_data;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic aw, input logic [4:0] ar, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md);
        bus.AluWrite = aw; bus.AluReg = ar; bus.AluData = ad;
        bus.MemValid = mv; bus.MemReg = mr; bus.MemData = md;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
`ifdef WB_PENDING_QUERY_EN
        bus.QueryReg1 = 5'd0;
        bus.QueryReg2 = 5'd0;
`endif
        last  = '0;
        Reset = 1'b1;
        #2;
        chk("rst_regwrite", bus.RegWrite, 0);
        chk("rst_wreg", bus.WriteRegister, 0);
        chk("rst_wdata", bus.WriteData, 0);
        chk("rst_memready", bus.MemReady, 0);
        chk("rst_aluready", bus.AluReady, 1);
        @(negedge Clk);
        Reset = 1'b0;

        // lone ALU write
        v(1, 5, 32'h1234, 0, 0, 0,       1, 1, 1, 5, 32'h1234);
        v(0, 0, 0,        0, 0, 0,       1, 1, 0, 0, 0);
        // four memory writes in order
        v(0, 0, 0, 1, 1, 32'h11,         1, 1, 0, 0, 0);
        v(0, 0, 0, 1, 2, 32'h22,         1, 1, 1, 1, 32'h11);
        v(0, 0, 0, 1, 3, 32'h33,         1, 1, 1, 2, 32'h22);
        v(0, 0, 0, 1, 4, 32'h44,         1, 1, 1, 3, 32'h33);
        v(0, 0, 0, 0, 0, 0,              1, 1, 1, 4, 32'h44);
        v(0, 0, 0, 0, 0, 0,              1, 1, 0, 0, 0);
        // ALU held on r7, FIFO fills, starvation bound and full back-pressure
        v(1, 7, 32'h70, 1, 10, 32'hA0,   1, 1, 1, 7, 32'h70);
        v(1, 7, 32'h71, 1, 11, 32'hA1,   1, 1, 1, 7, 32'h71);
        v(1, 7, 32'h72, 1, 12, 32'hA2,   1, 1, 1, 7, 32'h72);
        v(1, 7, 32'h73, 1, 13, 32'hA3,   1, 1, 1, 7, 32'h73);
        v(1, 7, 32'h74, 1, 14, 32'hEE,   0, 0, 1, 10, 32'hA0);
        v(1, 7, 32'h74, 1, 14, 32'hEE,   1, 1, 1, 7, 32'h74);
        v(1, 7, 32'h76, 0, 0, 0,         1, 0, 1, 7, 32'h76);
        v(1, 7, 32'h77, 0, 0, 0,         1, 0, 1, 7, 32'h77);
        v(1, 7, 32'h78, 0, 0, 0,         0, 0, 1, 11, 32'hA1);
        v(1, 7, 32'h78, 0, 0, 0,         1, 1, 1, 7, 32'h78);
        v(0, 0, 0, 0, 0, 0,              1, 1, 1, 12, 32'hA2);
        v(0, 0, 0, 0, 0, 0,              1, 1, 1, 13, 32'hA3);
        v(0, 0, 0, 0, 0, 0,              1, 1, 1, 14, 32'hEE);
        v(0, 0, 0, 0, 0, 0,              1, 1, 0, 0, 0);
        // WAW kill: queued r9 superseded by ALU r9
        v(0, 0, 0, 1, 9, 32'hAAAA,       1, 1, 0, 0, 0);
        v(1, 9, 32'hBBBB, 0, 0, 0,       1, 1, 1, 9, 32'hBBBB);
        v(0, 0, 0, 0, 0, 0,              1, 1, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0,              1, 1, 0, 0, 0);
        // register 0 discarded; same-cycle ALU/MEM to r3
        v(1, 0, 32'h5, 1, 0, 32'h6,      1, 1, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0,              1, 1, 0, 0, 0);
        v(1, 3, 32'h333, 1, 3, 32'h444,  1, 1, 1, 3, 32'h333);
        v(0, 0, 0, 0, 0, 0,              1, 1, 1, 3, 32'h444);
        v(0, 0, 0, 0, 0, 0,              1, 1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].aw, vecs[i].ar, vecs[i].ad, vecs[i].mv, vecs[i].mr, vecs[i].md);
            #1;
            chk($sformatf("alu_ready[%0d]", i), bus.AluReady, vecs[i].e_ar);
            chk($sformatf("mem_ready[%0d]", i), bus.MemReady, vecs[i].e_mr);
            if (vecs[i].e_we) sb.push_back({vecs[i].e_reg, vecs[i].e_data});
            @(posedge Clk);
            #1;
            chk($sformatf("reg_write[%0d]", i), bus.RegWrite, vecs[i].e_we);
            if (bus.RegWrite) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_pop[%0d]: got unexpected write r%0d expected none", i, bus.WriteRegister);
                end else begin
                    last = sb.pop_front();
                    chk($sformatf("wreg[%0d]", i), bus.WriteRegister, last.r);
                    chk($sformatf("wdata[%0d]", i), bus.WriteData, last.d);
                end
            end else begin
                chk($sformatf("hold_reg[%0d]", i), bus.WriteRegister, last.r);
                chk($sformatf("hold_data[%0d]", i), bus.WriteData, last.d);
            end
        end
        chk("sb_empty", sb.size(), 0);

`ifdef WB_PENDING_QUERY_EN
        drive(1, 1, 32'h1, 1, 6, 32'h66);
        @(posedge Clk); #1;
        drive(1, 1, 32'h2, 0, 0, 0);
        bus.QueryReg1 = 5'd6;
        bus.QueryReg2 = 5'd0;
        #1;
        chk("pend1_queued", bus.Pending1, 1);
        chk("pend2_zero", bus.Pending2, 0);
        @(posedge Clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        @(posedge Clk); #1;
        chk("pend_issue_we", bus.RegWrite, 1);
        chk("pend_issue_reg", bus.WriteRegister, 6);
        chk("pend1_outstage", bus.Pending1, 1);
        @(posedge Clk); #1;
        chk("pend1_done", bus.Pending1, 0);
        bus.QueryReg1 = 5'd0;
`endif

        // reset with three writes queued behind a busy ALU
        drive(1, 1, 32'h10, 1, 20, 32'h20);
        @(posedge Clk); #1;
        drive(1, 1, 32'h11, 1, 21, 32'h21);
        @(posedge Clk); #1;
        drive(1, 1, 32'h12, 1, 22, 32'h22);
        @(posedge Clk); #1;
        chk("pre_rst_we", bus.RegWrite, 1);
        chk("pre_rst_aluready", bus.AluReady, 1);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        Reset = 1'b1;
        #1;
        chk("arst_regwrite", bus.RegWrite, 0);
        chk("arst_wreg", bus.WriteRegister, 0);
        chk("arst_wdata", bus.WriteData, 0);
        chk("arst_memready", bus.MemReady, 0);
        chk("arst_aluready", bus.AluReady, 1);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("post_rst_memready", bus.MemReady, 1);
        for (int k = 0; k < 6; k++) begin
            @(posedge Clk); #1;
            chk($sformatf("post_rst_we[%0d]", k), bus.RegWrite, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
